// File: rtl/uart_pkg.sv
// Shared UART definitions: register offsets, STATUS/CTRL bit positions,
// transmitter FSM states and the default baud divisor.
package uart_pkg;

  localparam logic [11:0] UART_TXDATA = 12'h000;
  localparam logic [11:0] UART_STATUS = 12'h004;
  localparam logic [11:0] UART_DIV    = 12'h008;
  localparam logic [11:0] UART_CTRL   = 12'h00C;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;

  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_IRQ_EN = 1;

  // 100 MHz / 115200 baud
  localparam logic [15:0] UART_DIV_RESET = 16'd868;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; a push into a full FIFO is
// accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign count     = r_count;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: register file, TX FIFO, serialiser
// and drain interrupt.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int          XLEN       = 32,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = UART_DIV_RESET
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic            we,
  input  logic [11:0]     addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata,
  output logic            rvalid,
  output logic            txd,
  output logic            irq
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [15:0]      r_div;
  logic [1:0]       r_ctrl;
  logic             r_ovf;
  logic [XLEN-1:0]  r_rdata;
  logic             r_rvalid;
  logic             r_irq;
  uart_tx_state_e   r_state;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit_idx;
  logic [15:0]      r_baud_cnt;
  logic             r_txd;

  logic [11:0]      w_off;
  logic             w_wr;
  logic             w_rd;
  logic             w_push_req;
  logic             w_pop;
  logic [7:0]       w_fifo_rdata;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic [3:0]       w_cnt_sat;
  logic [15:0]      w_div_eff;
  logic             w_baud_done;
  logic             w_busy;
  logic [XLEN-1:0]  w_rd_data;
  logic             w_unused;

  assign w_off       = {addr[11:2], 2'b00};
  assign w_wr        = req & we;
  assign w_rd        = req & ~we;
  assign w_push_req  = w_wr & (w_off == UART_TXDATA);
  assign w_div_eff   = (r_div == 16'd0) ? 16'd1 : r_div;
  assign w_baud_done = (r_baud_cnt == 16'd0);
  assign w_busy      = (r_state != ST_IDLE);
  assign w_cnt_sat   = (32'(w_count) > 32'd15) ? 4'hF : 4'(w_count);
  assign w_unused    = ^{wdata[XLEN-1:16], addr[1:0]};

  // Pop when starting from idle, or at the end of a stop bit for back-to-back frames.
  assign w_pop = r_ctrl[CTRL_TX_EN] & ~w_empty &
                 ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_baud_done));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push_req),
    .pop   (w_pop),
    .wdata (wdata[7:0]),
    .rdata (w_fifo_rdata),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_comb begin
    w_rd_data = '0;
    case (w_off)
      UART_STATUS: begin
        w_rd_data[STAT_FULL]           = w_full;
        w_rd_data[STAT_EMPTY]          = w_empty;
        w_rd_data[STAT_BUSY]           = w_busy;
        w_rd_data[STAT_OVF]            = r_ovf;
        w_rd_data[STAT_CNT_LSB +: 4]   = w_cnt_sat;
      end
      UART_DIV:  w_rd_data[15:0] = r_div;
      UART_CTRL: w_rd_data[1:0]  = r_ctrl;
      default:   w_rd_data       = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div    <= DIV_RESET;
      r_ctrl   <= 2'b00;
      r_ovf    <= 1'b0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_rvalid <= w_rd;
      if (w_rd) begin
        r_rdata <= w_rd_data;
      end
      if (w_wr && (w_off == UART_DIV)) begin
        r_div <= wdata[15:0];
      end
      if (w_wr && (w_off == UART_CTRL)) begin
        r_ctrl <= wdata[1:0];
      end
      if (w_push_req && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end else if (w_wr && (w_off == UART_STATUS) && wdata[STAT_OVF]) begin
        r_ovf <= 1'b0;
      end
      r_irq <= r_ctrl[CTRL_IRQ_EN] & w_empty & ~w_busy;
    end
  end

  // Each bit lasts max(DIV,1) cycles; the counter reloads at every bit boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_txd      <= 1'b1;
      r_shift    <= 8'h00;
      r_bit_idx  <= 3'd0;
      r_baud_cnt <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_state    <= ST_START;
            r_shift    <= w_fifo_rdata;
            r_txd      <= 1'b0;
            r_baud_cnt <= w_div_eff - 16'd1;
          end
        end
        ST_START: begin
          if (w_baud_done) begin
            r_state    <= ST_DATA;
            r_txd      <= r_shift[0];
            r_shift    <= {1'b0, r_shift[7:1]};
            r_bit_idx  <= 3'd0;
            r_baud_cnt <= w_div_eff - 16'd1;
          end else begin
            r_baud_cnt <= r_baud_cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (w_baud_done) begin
            r_baud_cnt <= w_div_eff - 16'd1;
            if (r_bit_idx == 3'd7) begin
              r_state <= ST_STOP;
              r_txd   <= 1'b1;
            end else begin
              r_txd     <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt - 16'd1;
          end
        end
        ST_STOP: begin
          if (w_baud_done) begin
            if (w_pop) begin
              r_state    <= ST_START;
              r_shift    <= w_fifo_rdata;
              r_txd      <= 1'b0;
              r_baud_cnt <= w_div_eff - 16'd1;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt - 16'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign txd    = r_txd;
  assign irq    = r_irq;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register access, frame timing, FIFO
// overflow, back-to-back frames, interrupt and mid-frame reset.
module tb_uart_tx_mmio;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        txd;
  logic        irq;

  int errors = 0;
  int checks = 0;

  logic [255:0] cap_v;
  logic [255:0] exp_v;
  int           exp_n;
  logic [31:0]  rd_d;
  logic         rd_v;

  always #5 clk = ~clk;

  uart_tx_mmio dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .rvalid (rvalid),
    .txd    (txd),
    .irq    (irq)
  );

  task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [11:0] a, output logic [31:0] d, output logic v);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    req = 1'b0;
    d = rdata;
    v = rvalid;
  endtask

  task automatic exp_clear();
    exp_v = '0;
    cap_v = '0;
    exp_n = 0;
  endtask

  task automatic add_bits(input logic val, input int n);
    for (int i = 0; i < n; i++) begin
      exp_v[exp_n] = val;
      exp_n++;
    end
  endtask

  task automatic add_frame(input logic [7:0] b, input int div);
    add_bits(1'b0, div);
    for (int i = 0; i < 8; i++) add_bits(b[i], div);
    add_bits(1'b1, div);
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap_v[i] = txd;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({txd, rvalid, irq, rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_outputs: txd=%b rvalid=%b irq=%b rdata=%h, want 1 0 0 0", txd, rvalid, irq, rdata);
    end
    rst = 1'b0;
    bus_read(12'h004, rd_d, rd_v);
    checks++;
    if (rd_d !== 32'h2 || rd_v !== 1'b1) begin
      errors++;
      $display("FAIL reset_status: rdata=%h rvalid=%b, want 00000002 1", rd_d, rd_v);
    end
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b0 || rdata !== 32'h2) begin
      errors++;
      $display("FAIL rvalid_pulse: rvalid=%b rdata=%h, want 0 00000002 (held)", rvalid, rdata);
    end
    bus_read(12'h008, rd_d, rd_v);
    checks++;
    if (rd_d !== 32'd868) begin
      errors++;
      $display("FAIL reset_div: got %0d, want 868", rd_d);
    end
    bus_read(12'h00B, rd_d, rd_v);
    checks++;
    if (rd_d !== 32'd868) begin
      errors++;
      $display("FAIL div_low_bits_ignored: got %0d, want 868", rd_d);
    end
    bus_read(12'h00C, rd_d, rd_v);
    checks++;
    if (rd_d !== 32'h0) begin
      errors++;
      $display("FAIL reset_ctrl: got %h, want 0", rd_d);
    end
    bus_read(12'h010, rd_d, rd_v);
    checks++;
    if (rd_d !== 32'h0 || rd_v !== 1'b1) begin
      errors++;
      $display("FAIL unmapped_read: rdata=%h rvalid=%b, want 0 1", rd_d, rd_v);
    end
    checks++;
    if (txd !== 1'b1) begin
      errors++;
      $display("FAIL idle_txd: got %b, want 1", txd);
    end
  endtask

  task automatic test_single_frame();
    bus_write(12'h008, 32'd4);
    bus_write(12'h00C, 32'h1);
    exp_clear();
    add_frame(8'hA5, 4);
    add_bits(1'b1, 4);
    bus_write(12'h000, 32'hA5);
    capture(exp_n);
    checks++;
    if (cap_v !== exp_v) begin
      errors++;
      $display("FAIL frame_a5: got %h, want %h", cap_v, exp_v);
    end
    bus_read(12'h004, rd_d, rd_v);
    checks++;
    if (rd_d !== 32'h2) begin
      errors++;
      $display("FAIL status_after_frame: got %h, want 00000002", rd_d);
    end
    bus_read(12'h000, rd_d, rd_v);
    checks++;
    if (rd_d !== 32'h0) begin
      errors++;
      $display("FAIL txdata_read: got %h, want 0", rd_d);
    end
  endtask

  task automatic test_div_change();
    exp_clear();
    add_bits(1'b0, 4);
    add_bits(1'b0, 4);
    add_bits(1'b0, 4);
    for (int i = 2; i < 8; i++) add_bits(((8'h3C >> i) & 8'h1) != 0, 8);
    add_bits(1'b1, 8);
    add_bits(1'b1, 4);
    bus_write(12'h008, 32'd4);
    bus_write(12'h000, 32'h3C);
    for (int k = 1; k <= exp_n; k++) begin
      @(negedge clk);
      cap_v[k-1] = txd;
      if (k == 9) begin
        req = 1'b1; we = 1'b1; addr = 12'h008; wdata = 32'd8;
      end else if (k == 10) begin
        req = 1'b0; we = 1'b0;
      end else if (k == 20) begin
        req = 1'b1; we = 1'b0; addr = 12'h004;
      end else if (k == 21) begin
        req = 1'b0;
        rd_d = rdata;
      end
    end
    checks++;
    if (cap_v !== exp_v) begin
      errors++;
      $display("FAIL div_change_frame: got %h, want %h", cap_v, exp_v);
    end
    checks++;
    if (rd_d !== 32'h6) begin
      errors++;
      $display("FAIL status_busy: got %h, want 00000006", rd_d);
    end
    bus_write(12'h008, 32'd0);
    exp_clear();
    add_frame(8'h96, 1);
    add_bits(1'b1, 2);
    bus_write(12'h000, 32'h96);
    capture(exp_n);
    checks++;
    if (cap_v !== exp_v) begin
      errors++;
      $display("FAIL div_zero_frame: got %h, want %h", cap_v, exp_v);
    end
  endtask

  task automatic test_overflow_back_to_back();
    bus_write(12'h00C, 32'h0);
    bus_write(12'h008, 32'd2);
    for (int i = 0; i < 9; i++) bus_write(12'h000, 32'h30 + 32'(i));
    bus_read(12'h004, rd_d, rd_v);
    checks++;
    if (rd_d !== 32'h89) begin
      errors++;
      $display("FAIL status_overflow: got %h, want 00000089", rd_d);
    end
    bus_write(12'h004, 32'h8);
    bus_read(12'h004, rd_d, rd_v);
    checks++;
    if (rd_d !== 32'h81) begin
      errors++;
      $display("FAIL overflow_clear: got %h, want 00000081", rd_d);
    end
    exp_clear();
    for (int i = 0; i < 8; i++) add_frame(8'h30 + 8'(i), 2);
    add_bits(1'b1, 24);
    bus_write(12'h00C, 32'h1);
    capture(exp_n);
    checks++;
    if (cap_v !== exp_v) begin
      errors++;
      $display("FAIL back_to_back: got %h, want %h", cap_v, exp_v);
    end
    bus_read(12'h004, rd_d, rd_v);
    checks++;
    if (rd_d !== 32'h2) begin
      errors++;
      $display("FAIL status_drained: got %h, want 00000002", rd_d);
    end
  endtask

  task automatic test_irq();
    int bad;
    bus_write(12'h008, 32'd2);
    bus_write(12'h00C, 32'h3);
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_idle: got %b, want 1", irq);
    end
    bus_write(12'h000, 32'h5A);
    bad = 0;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      if (irq !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL irq_busy: irq high in %0d cycles, want 0", bad);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_after_stop: got %b, want 1", irq);
    end
    bus_write(12'h00C, 32'h1);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_lag: got %b, want 1", irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_disable: got %b, want 0", irq);
    end
  endtask

  task automatic test_reset_midframe();
    bus_write(12'h008, 32'd4);
    bus_write(12'h000, 32'hC3);
    bus_write(12'h000, 32'h55);
    repeat (16) @(negedge clk);
    checks++;
    if (txd !== 1'b0) begin
      errors++;
      $display("FAIL bit3_before_rst: got %b, want 0", txd);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (txd !== 1'b1) begin
      errors++;
      $display("FAIL rst_txd: got %b, want 1", txd);
    end
    bus_read(12'h004, rd_d, rd_v);
    checks++;
    if (rd_d !== 32'h2) begin
      errors++;
      $display("FAIL rst_status: got %h, want 00000002", rd_d);
    end
    bus_write(12'h00C, 32'h1);
    exp_clear();
    add_bits(1'b1, 40);
    capture(exp_n);
    checks++;
    if (cap_v !== exp_v) begin
      errors++;
      $display("FAIL no_frame_after_rst: got %h, want %h", cap_v, exp_v);
    end
    bus_read(12'h008, rd_d, rd_v);
    checks++;
    if (rd_d !== 32'd868) begin
      errors++;
      $display("FAIL rst_div: got %0d, want 868", rd_d);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_div_change();
    test_overflow_back_to_back();
    test_irq();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
